// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read/1-write general-purpose register file.
package regfile_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } mode_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: a DEPTH:1 mux over the storage array, with
// optional forwarding of the in-flight write when the addresses collide.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b0
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] entries,
  input  logic [ADDR_W-1:0]                  readAddress,
  input  logic                               writeActive,
  input  logic [ADDR_W-1:0]                  writeAddress,
  input  logic [DATA_W-1:0]                  writeValue,
  output logic [DATA_W-1:0]                  readValue
);

  logic collide;

  // Forwarding only exists when BYPASS is set; otherwise the stored value wins
  // until the write edge.
  assign collide   = BYPASS && writeActive && (writeAddress == readAddress);
  assign readValue = collide ? writeValue : entries[readAddress];

endmodule

// File: rtl/regfile_2r1w.sv
// 32 x 16-bit register file: clocked write port with synchronous reset,
// two zero-latency read ports. Entry 0 is an ordinary register.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [ADDR_W-1:0] WriteAddress,
  input  logic [DATA_W-1:0] WriteValue,
  input  logic [ADDR_W-1:0] ReadAddress1,
  input  logic [ADDR_W-1:0] ReadAddress2,
  output logic [DATA_W-1:0] ReadValue1,
  output logic [DATA_W-1:0] ReadValue2
);

  localparam int NUM_ENTRIES = 2 ** ADDR_W;

  logic [NUM_ENTRIES-1:0][DATA_W-1:0] entries;
  logic                               writeActive;

  assign writeActive = (mode_t'(mode) == MODE_WRITE);

  // Reset clears the whole array and overrides any write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      entries <= '0;
    end else if (writeActive) begin
      entries[WriteAddress] <= WriteValue;
    end
  end

  regfile_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .BYPASS(BYPASS)
  ) readPort1 (
    .entries     (entries),
    .readAddress (ReadAddress1),
    .writeActive (writeActive),
    .writeAddress(WriteAddress),
    .writeValue  (WriteValue),
    .readValue   (ReadValue1)
  );

  regfile_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .BYPASS(BYPASS)
  ) readPort2 (
    .entries     (entries),
    .readAddress (ReadAddress2),
    .writeActive (writeActive),
    .writeAddress(WriteAddress),
    .writeValue  (WriteValue),
    .readValue   (ReadValue2)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Drives one register file without forwarding and one with forwarding from the
// same stimulus; expectations go through a scoreboard queue.
module tb_regfile_2r1w;

  logic        clk;
  logic        reset;
  logic        mode;
  logic [4:0]  WriteAddress;
  logic [15:0] WriteValue;
  logic [4:0]  ReadAddress1;
  logic [4:0]  ReadAddress2;
  logic [15:0] plainRead1, plainRead2;
  logic [15:0] bypassRead1, bypassRead2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          port;
    logic [15:0] expected;
  } sbEntry_t;

  sbEntry_t    scoreboard[$];
  logic [15:0] model[32];

  regfile_2r1w #(.DATA_W(16), .ADDR_W(5), .BYPASS(1'b0)) dutPlain (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .WriteAddress(WriteAddress),
    .WriteValue  (WriteValue),
    .ReadAddress1(ReadAddress1),
    .ReadAddress2(ReadAddress2),
    .ReadValue1  (plainRead1),
    .ReadValue2  (plainRead2)
  );

  regfile_2r1w #(.DATA_W(16), .ADDR_W(5), .BYPASS(1'b1)) dutBypass (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .WriteAddress(WriteAddress),
    .WriteValue  (WriteValue),
    .ReadAddress1(ReadAddress1),
    .ReadAddress2(ReadAddress2),
    .ReadValue1  (bypassRead1),
    .ReadValue2  (bypassRead2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic m, input logic [4:0] wa,
                               input logic [15:0] wv, input logic [4:0] ra1,
                               input logic [4:0] ra2);
    reset        = r;
    mode         = m;
    WriteAddress = wa;
    WriteValue   = wv;
    ReadAddress1 = ra1;
    ReadAddress2 = ra2;
    #1;
  endtask

  // The model follows the same edge the DUTs see; sampling happens 1 time unit later.
  task automatic clockEdge();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 16'h0000;
    end else if (mode) begin
      model[WriteAddress] = WriteValue;
    end
    #1;
  endtask

  task automatic pushExpect(input string tag, input logic [15:0] p1, input logic [15:0] p2,
                            input logic [15:0] b1, input logic [15:0] b2);
    scoreboard.push_back('{tag, 0, p1});
    scoreboard.push_back('{tag, 1, p2});
    scoreboard.push_back('{tag, 2, b1});
    scoreboard.push_back('{tag, 3, b2});
  endtask

  task automatic pushFromModel(input string tag);
    logic [15:0] b1, b2;
    b1 = (mode && WriteAddress == ReadAddress1) ? WriteValue : model[ReadAddress1];
    b2 = (mode && WriteAddress == ReadAddress2) ? WriteValue : model[ReadAddress2];
    pushExpect(tag, model[ReadAddress1], model[ReadAddress2], b1, b2);
  endtask

  function automatic logic [15:0] portValue(input int port);
    case (port)
      0:       return plainRead1;
      1:       return plainRead2;
      2:       return bypassRead1;
      default: return bypassRead2;
    endcase
  endfunction

  task automatic checkOutput();
    sbEntry_t    e;
    logic [15:0] observed;
    while (scoreboard.size() > 0) begin
      e        = scoreboard.pop_front();
      observed = portValue(e.port);
      checks++;
      assert (observed === e.expected)
      else begin
        errors++;
        $error("[TB] FAIL %s port%0d observed=%h expected=%h", e.tag, e.port, observed,
               e.expected);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 16'hxxxx;

    // Reset wins over a simultaneous write.
    applyStimulus(1'b1, 1'b1, 5'd0, 16'h1232, 5'd0, 5'd1);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 5'd0, 16'h1232, 5'd0, 5'd1);
    pushExpect("reset_wins", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    checkOutput();

    applyStimulus(1'b0, 1'b1, 5'd0, 16'h1232, 5'd0, 5'd1);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 5'd0, 16'h1232, 5'd0, 5'd1);
    pushExpect("write_entry0", 16'h1232, 16'h0000, 16'h1232, 16'h0000);
    checkOutput();

    applyStimulus(1'b0, 1'b1, 5'd1, 16'h1263, 5'd0, 5'd1);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 5'd1, 16'h1263, 5'd0, 5'd1);
    pushExpect("write_entry1", 16'h1232, 16'h1263, 16'h1232, 16'h1263);
    checkOutput();

    // Read mode must block writes over several edges.
    applyStimulus(1'b0, 1'b0, 5'd2, 16'hFFFF, 5'd1, 5'd2);
    for (int i = 0; i < 3; i++) clockEdge();
    pushExpect("read_mode_blocks", 16'h1263, 16'h0000, 16'h1263, 16'h0000);
    checkOutput();

    applyStimulus(1'b0, 1'b1, 5'd2, 16'hA06B, 5'd1, 5'd2);
    pushExpect("pre_edge_entry2", 16'h1263, 16'h0000, 16'h1263, 16'hA06B);
    checkOutput();
    clockEdge();
    applyStimulus(1'b0, 1'b0, 5'd2, 16'hA06B, 5'd1, 5'd2);
    pushExpect("write_entry2", 16'h1263, 16'hA06B, 16'h1263, 16'hA06B);
    checkOutput();

    // Same-address collision on entry 31, both ports.
    applyStimulus(1'b0, 1'b1, 5'd31, 16'h5A5A, 5'd31, 5'd31);
    pushExpect("collide_before", 16'h0000, 16'h0000, 16'h5A5A, 16'h5A5A);
    checkOutput();
    clockEdge();
    pushExpect("collide_after", 16'h5A5A, 16'h5A5A, 16'h5A5A, 16'h5A5A);
    checkOutput();

    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(i), 16'h0100 + 16'(i), 5'd0, 5'd31);
      clockEdge();
    end
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 5'(i), 16'hDEAD, 5'(i), 5'(31 - i));
      pushExpect("sweep", 16'h0100 + 16'(i), 16'h0100 + 16'(31 - i),
                 16'h0100 + 16'(i), 16'h0100 + 16'(31 - i));
      checkOutput();
    end

    // Raising reset must not disturb anything before the edge.
    applyStimulus(1'b1, 1'b0, 5'd0, 16'h0000, 5'd5, 5'd26);
    pushExpect("reset_not_async", 16'h0105, 16'h011A, 16'h0105, 16'h011A);
    checkOutput();
    clockEdge();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 16'h0000, 5'(i), 5'(31 - i));
      pushFromModel("sweep_reset");
      pushExpect("sweep_reset_const", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      checkOutput();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
